// File: rtl/mem_pkg.sv
// Shared constants for the memory access unit: func3 codes, FSM encoding,
// access sizes and base write strobes.
package mem_pkg;

    // Load/store access size and sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    // Access FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Access sizes in bytes, indexed by func3[1:0]
    localparam logic [3:0] SIZE_B = 4'd1;
    localparam logic [3:0] SIZE_H = 4'd2;
    localparam logic [3:0] SIZE_W = 4'd4;
    localparam logic [3:0] SIZE_D = 4'd8;

    // Byte strobes for an access at lane 0
    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    // Base strobe for a given size code
    function automatic logic [7:0] size_strobe(input logic [1:0] sz);
        logic [7:0] s;
        case (sz)
            2'd0:    s = STRB_B;
            2'd1:    s = STRB_H;
            2'd2:    s = STRB_W;
            default: s = STRB_D;
        endcase
        return s;
    endfunction

    // Low address bits that must be zero for an aligned access (size - 1)
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            2'd0:    n = SIZE_B;
            2'd1:    n = SIZE_H;
            2'd2:    n = SIZE_W;
            default: n = SIZE_D;
        endcase
        return 3'(n - 4'd1);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: moves the addressed bytes of a 64-bit memory word
// down to bit 0 and sign- or zero-extends them according to func3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  func3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    // Shift the addressed lane down, then extend to 64 bits
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (func3)
            F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  result = {56'd0, shifted[7:0]};
            F3_LHU:  result = {48'd0, shifted[15:0]};
            F3_LWU:  result = {32'd0, shifted[31:0]};
            // LD, and the illegal code which never reaches a request
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit. Issues one request per load/store held in
// the EXE/MEM register, stalls the pipeline until the memory acknowledges, and
// registers the extended load result. Misaligned or illegal accesses raise a
// one-cycle error flag instead of a request.
//
// Memory handshake: dmem_req is held high with dmem_we/addr/wdata/wstrb stable
// from the cycle after issue until the first rising clock edge where dmem_ack
// is high; that edge completes the transfer and dmem_req drops on it. dmem_ack
// is ignored whenever no request is outstanding.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] mr,
    input  logic [63:0] mqb,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [2:0]  mfunc3,
    output logic [63:0] mmo,
    output logic        stall,
    output logic        merr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [1:0]  state_o      // FSM state for observation
);

    mem_state_e  state_q;
    logic        req_q;
    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic [63:0] mmo_q;
    logic        merr_q;
    logic [2:0]  off_q;
    logic [2:0]  f3_q;

    logic        is_store;
    logic        is_load;
    logic        is_mem;
    logic        illegal;
    logic        misaligned;
    logic        acc_ok;
    logic        acc_bad;
    logic [7:0]  st_strb_d;
    logic [63:0] st_wdata_d;
    logic [63:0] load_result;

    // Decode the instruction in EXE/MEM: kind, legality, alignment, store lanes
    always_comb begin
        is_store   = mwmem;
        is_load    = mm2reg & ~mwmem;
        is_mem     = is_store | is_load;
        illegal    = (mfunc3 == F3_ILL) | (is_store & mfunc3[2]);
        misaligned = (mr[2:0] & align_mask(mfunc3[1:0])) != 3'b000;
        acc_ok     = is_mem & ~illegal & ~misaligned;
        acc_bad    = is_mem & (illegal | misaligned);
        st_strb_d  = size_strobe(mfunc3[1:0]) << mr[2:0];
        st_wdata_d = mqb << {mr[2:0], 3'b000};
    end

    mem_load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .func3  (f3_q),
        .result (load_result)
    );

    // Access FSM: issue in IDLE, wait for ack, release the pipeline in DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wstrb_q <= 8'd0;
            mmo_q   <= 64'd0;
            merr_q  <= 1'b0;
            off_q   <= 3'd0;
            f3_q    <= 3'd0;
        end else begin
            merr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc_ok) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {mr[63:3], 3'b000};
                        wdata_q <= is_store ? st_wdata_d : 64'd0;
                        wstrb_q <= is_store ? st_strb_d : 8'd0;
                        off_q   <= mr[2:0];
                        f3_q    <= mfunc3;
                        state_q <= ST_WAIT;
                    end else if (acc_bad) begin
                        merr_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            mmo_q <= load_result;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The pipeline advances on this edge; never reissue
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall from the issuing IDLE cycle through the last WAIT cycle
    assign stall = rstn & (((state_q == ST_IDLE) & acc_ok) | (state_q == ST_WAIT));

    assign mmo        = mmo_q;
    assign merr       = merr_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign state_o    = state_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port mr, input, 64, byte address (EXE result) of the instruction held in the EXE/MEM register.
REQ-004 SHALL have port mqb, input, 64, rs2 store data.
REQ-005 SHALL have port mwmem, input, 1, store request.
REQ-006 SHALL have port mm2reg, input, 1, load request.
REQ-007 SHALL have port mfunc3, input, 3, access size and sign code.
REQ-008 SHALL have port mmo, output, 64, registered load result, sign- or zero-extended.
REQ-009 SHALL have port stall, output, 1, freeze request to the PC and all upstream pipeline registers.
REQ-010 SHALL have port merr, output, 1, registered one-cycle misaligned or illegal access flag.
REQ-011 SHALL have ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, 64, bits [2:0]=0), dmem_wdata (out, 64), dmem_wstrb (out, 8), dmem_rdata (in, 64) and dmem_ack (in, 1), forming the data-memory handshake.

Function
REQ-012 SHALL treat mwmem=1 as a store and mm2reg=1 (with mwmem=0) as a load; mwmem has priority when both are set.
REQ-013 SHALL decode mfunc3 as follows: 000 byte, 001 half, 010 word, 011 double, 100 byte unsigned, 101 half unsigned, 110 word unsigned; 111 is illegal, and codes 1xx are illegal for stores.
REQ-014 SHALL classify an access as misaligned when mr is not a multiple of its size.
REQ-015 SHALL run an FSM with three states: IDLE, WAIT and DONE.
REQ-016 In IDLE with a valid, aligned access, SHALL assert stall combinationally, register dmem_req=1 with dmem_we, dmem_addr, dmem_wdata and dmem_wstrb, and go to WAIT.
REQ-017 In WAIT, SHALL hold all dmem_* outputs stable and keep stall=1 until dmem_ack=1.
REQ-018 On the dmem_ack edge, SHALL drop dmem_req, go to DONE, and for a load register the extracted and extended lane of dmem_rdata into mmo.
REQ-019 In DONE, SHALL hold stall=0 so that the pipeline advances on that edge, then return to IDLE unconditionally with no reissue.
REQ-020 SHALL accept dmem_ack in the first WAIT cycle, giving a minimum access of IDLE, WAIT, DONE (3 cycles, 2 stall cycles).
REQ-021 SHALL ignore dmem_ack outside WAIT.
REQ-022 For a misaligned or illegal access in IDLE, SHALL issue no request and assert no stall, pulse merr for one cycle, and leave mmo unchanged.
REQ-023 For instructions with no memory access, SHALL assert no stall and leave mmo unchanged.
REQ-024 For stores, SHALL shift the store data to byte lane mr[2:0] and set dmem_wstrb to 0x01, 0x03, 0x0F or 0xFF shifted left by mr[2:0].
REQ-025 For loads, SHALL drive dmem_wstrb=0x00 and dmem_we=0.

Reset
REQ-026 rstn=0 SHALL force the state to IDLE and set dmem_req=0, dmem_we=0, dmem_wstrb=0, mmo=0 and merr=0 immediately, regardless of clk.
REQ-027 A reset asserted in WAIT SHALL abandon the access, and an ack arriving after the reset SHALL be ignored.
REQ-028 stall SHALL be 0 while rstn=0.

Structure
REQ-029 SHALL take the func3 codes, the state encoding and the size and strobe constants from the shared package mem_pkg.
REQ-030 SHALL place load lane extraction and extension in the combinational sub-module mem_load_align, with inputs rdata, offset and func3 and output the 64-bit result.

Verification
REQ-031 The bench SHALL apply LD with mr=0x1000 and ack in the first WAIT cycle, and check dmem_addr=0x1000, 2 stall cycles, and mmo equal to rdata in DONE.
REQ-032 The bench SHALL apply LB with mr=0x1003 and rdata=0x00000000_80000000, and check mmo=0xFFFFFFFF_FFFFFF80; with LBU the same access SHALL give mmo=0x80.
REQ-033 The bench SHALL apply SH with mr=0x2006 and mqb=0xABCD, and check dmem_wstrb=0xC0, dmem_wdata[63:48]=0xABCD and dmem_we=1.
REQ-034 The bench SHALL apply LW with mr=0x3002, and check merr pulsing 1 cycle, dmem_req=0, stall=0 and mmo unchanged.
REQ-035 The bench SHALL apply an SD with ack delayed 5 cycles, and check stall=1 for 6 cycles and dmem_* stable throughout WAIT.
REQ-036 The bench SHALL assert rstn=0 in WAIT, and check dmem_req=0 immediately and IDLE afterwards, with a stale ack ignored.
